// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states, datapath widths.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential pc+4 (wrapping) or taken-branch target,
// plus a flag for a target that is not 4-byte aligned.
module pc_next_logic #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] nxt,
    output logic              misaligned
);

    // Select the successor address and flag misalignment.
    always_comb begin
        nxt        = branch_taken ? branch_target : (pc + ADDR_W'(4));
        misaligned = (nxt[1:0] != 2'b00);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-pipelined fetch stage: owns the PC, issues one imem read per
// instruction, holds the returned word until execute retires it.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [6:0]         op,
    output logic [2:0]         funct3,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               misalign_err,
    output logic [31:0]        retire_count
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              retire;
    logic [ADDR_W-1:0] nxt_pc;
    logic              nxt_misaligned;
    logic [31:0]       retire_cnt;

    pc_next_logic #(
        .ADDR_W (ADDR_W)
    ) u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .nxt           (nxt_pc),
        .misaligned    (nxt_misaligned)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, request strobe and retire decode.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        retire    = 1'b0;
        unique case (state)
            FETCH: begin
                // Reset state is FETCH; gating with rst keeps the strobe low
                // while reset is held so no request escapes during reset.
                imem_req  = !rst;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    retire    = 1'b1;
                    state_nxt = nxt_misaligned ? HALT : FETCH;
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    // PC, instruction register, valid flag, error flag and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            retire_cnt   <= '0;
        end else begin
            instr_valid <= (state_nxt == HOLD);
            if (state == WAIT && imem_rvalid) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + 32'd1;
                if (nxt_misaligned) begin
                    misalign_err <= 1'b1;
                end else begin
                    pc <= nxt_pc;
                end
            end
        end
    end

    assign imem_addr    = pc;
    assign op           = instr[6:0];
    assign funct3       = instr[14:12];
    assign retire_count = retire_cnt;

endmodule
